// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode sequencer for an 8-bit accumulator-less ISA: fetches one- or two-byte
// instructions and drives register-file controls. Optional FETCH_STALL_CNT_EN adds a memory stall counter.
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [1:0] readreg1,
  output logic [1:0] readreg2,
  output logic [1:0] writereg,
  output logic       regwrite,
  output logic       alu_op,
  output logic       wb_sel,
  output logic [7:0] imm,
  output logic [7:0] pc,
  output logic       halted
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] IMM    = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;

  logic [1:0] opcode;
  logic       is_ldi;
  logic       is_jmp;

  assign opcode = ir_q[7:6];
  assign is_ldi = (opcode == 2'b10);
  assign is_jmp = (opcode == 2'b11) && (ir_q[5:4] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opcode[1] == 1'b0) begin
          state_d = EXEC;
        end else if (is_ldi || is_jmp) begin
          state_d = IMM;
        end else begin
          state_d = HALT;
        end
      end
      IMM: begin
        if (mem_ready) begin
          imm_d = mem_rdata;
          // A jump target replaces the PC outright; LDI just steps past its operand byte.
          if (is_jmp) begin
            pc_d    = mem_rdata;
            state_d = FETCH;
          end else begin
            pc_d    = pc_q + 8'd1;
            state_d = EXEC;
          end
        end
      end
      EXEC:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  assign mem_rd   = (state_q == FETCH) || (state_q == IMM);
  assign mem_addr = pc_q;
  assign readreg1 = ir_q[3:2];
  assign readreg2 = ir_q[1:0];
  assign writereg = ir_q[5:4];
  assign alu_op   = ir_q[6];
  assign regwrite = (state_q == EXEC);
  assign wb_sel   = (state_q == EXEC) && is_ldi;
  assign imm      = imm_q;
  assign pc       = pc_q;
  assign halted   = (state_q == HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_rd && !mem_ready && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 8'h00;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port mem_addr, output, 8 bits: instruction memory byte address.
REQ-005 SHALL have port mem_rd, output, 1 bit: memory read request.
REQ-006 SHALL have port mem_ready, input, 1 bit: mem_rdata valid this cycle.
REQ-007 SHALL have port mem_rdata, input, 8 bits: memory read data.
REQ-008 SHALL have ports readreg1, readreg2 and writereg, each output, 2 bits: register file select fields.
REQ-009 SHALL have port regwrite, output, 1 bit: register file write enable.
REQ-010 SHALL have port alu_op, output, 1 bit: 0 = ADD, 1 = SUB.
REQ-011 SHALL have port wb_sel, output, 1 bit: 0 = ALU result, 1 = immediate.
REQ-012 SHALL have port imm, output, 8 bits: the captured immediate byte.
REQ-013 SHALL have port pc, output, 8 bits: the current program counter.
REQ-014 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-015 SHALL decode the instruction register ir[7:0] as follows: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-016 SHALL decode opcodes as: 00 ADD, 01 SUB, 10 LDI rd,#imm (two-byte), 11 with rd=00 JMP #imm (two-byte), 11 with rd≠00 HALT.
REQ-017 SHALL use the state machine states FETCH, DECODE, IMM, EXEC and HALT.
REQ-018 SHALL, in FETCH, drive mem_rd=1 and mem_addr=pc; on mem_ready, load ir ← mem_rdata, set pc ← pc+1 and go to DECODE; otherwise hold FETCH with all state unchanged.
REQ-019 SHALL, in DECODE, go to EXEC for ADD/SUB, to IMM for LDI/JMP, and to HALT for HALT.
REQ-020 SHALL, in IMM, drive mem_rd=1 and mem_addr=pc; on mem_ready, load imm ← mem_rdata and pc ← pc+1, then go to EXEC for LDI.
REQ-021 SHALL, in IMM on mem_ready for JMP, set pc ← mem_rdata (no increment) and go to FETCH.
REQ-022 SHALL, in EXEC, assert regwrite=1 for exactly one cycle with writereg=rd, then go to FETCH.
REQ-023 SHALL assert regwrite in no state other than EXEC.
REQ-024 SHALL drive readreg1=ir[3:2], readreg2=ir[1:0], writereg=ir[5:4] and alu_op=ir[6] combinationally from ir in all states.
REQ-025 SHALL drive wb_sel=1 in EXEC for LDI and 0 otherwise.
REQ-026 SHALL make pc arithmetic modulo 256: 8'hFF+1 wraps to 8'h00.
REQ-027 SHALL make HALT absorbing: only rst leaves it, mem_rd=0, and halted=1.
REQ-028 SHALL keep mem_rd low in DECODE, EXEC and HALT.
REQ-029 SHALL have latency per instruction of: ADD/SUB = 3 cycles and LDI = 4 cycles with zero-wait memory; JMP = 3 cycles.

Reset
REQ-030 SHALL, on rst=1 at posedge clk, set state=FETCH, pc=RESET_PC, ir=8'h00, imm=8'h00, regwrite=0 and halted=0, regardless of state, including mid-handshake.
REQ-031 SHALL have rst take priority over mem_ready in the same cycle, so that no ir/imm/pc capture occurs.
REQ-032 SHALL, in the first cycle after reset release, drive mem_rd=1 with mem_addr=RESET_PC.

Configuration
REQ-033 SHALL, with FETCH_STALL_CNT_EN defined, add output stall_cnt, 8 bits, counting cycles where mem_rd=1 and mem_ready=0.
REQ-034 SHALL make stall_cnt saturate at 8'hFF and clear to 0 on rst.
REQ-035 SHALL, with FETCH_STALL_CNT_EN undefined, omit the stall_cnt port and counter logic entirely, leaving all other behaviour identical.

Verification
REQ-036 SHALL cover: rst, then mem at 0 = 8'h1B (ADD r1,r2,r3) with zero-wait -> readreg1=2, readreg2=3, writereg=1, regwrite pulses once in cycle 3, pc=1.
REQ-037 SHALL cover: bytes 8'hA0, 8'h5A (LDI r2,#5A) -> regwrite=1, wb_sel=1, imm=8'h5A, writereg=2 in cycle 4, pc=2.
REQ-038 SHALL cover: bytes 8'hC0, 8'h10 (JMP 10) -> next mem_addr=8'h10, regwrite never asserted.
REQ-039 SHALL cover: 8'hD0 (HALT) -> halted=1, mem_rd=0 for 20 cycles; rst -> pc=RESET_PC, halted=0.
REQ-040 SHALL cover: mem_ready held low 5 cycles in FETCH -> mem_addr and mem_rd stable, state unchanged; with FETCH_STALL_CNT_EN, stall_cnt=5.
REQ-041 SHALL cover: pc=8'hFF fetch of ADD -> pc=8'h00; rst asserted with mem_ready in IMM -> imm stays 8'h00, state FETCH.
